// File: rtl/text_glyph_ram_controller_if.sv
// Port-B bundle of the glyph RAM controller: CPU byte channel,
// bulk command channel and the RAM-side signals.
interface text_glyph_ram_controller_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    logic                  cpuValid;
    logic                  cpuReady;
    logic                  cpuWrite;
    logic [ADDR_WIDTH-1:0] cpuAddress;
    logic [DATA_WIDTH-1:0] cpuWriteData;
    logic                  cpuReadValid;
    logic [DATA_WIDTH-1:0] cpuReadData;

    logic                  cmdValid;
    logic                  cmdReady;
    logic                  cmdOp;
    logic [7:0]            cmdSrc;
    logic [7:0]            cmdDst;
    logic [7:0]            cmdCount;
    logic                  busy;
    logic                  done;

    logic                  ramEnable;
    logic                  ramWriteEnable;
    logic [ADDR_WIDTH-1:0] ramAddress;
    logic [DATA_WIDTH-1:0] ramDataIn;
    logic [DATA_WIDTH-1:0] ramDataOut;

    modport master (
        output cpuValid, cpuWrite, cpuAddress, cpuWriteData,
        output cmdValid, cmdOp, cmdSrc, cmdDst, cmdCount,
        output ramDataOut,
        input  cpuReady, cpuReadValid, cpuReadData,
        input  cmdReady, busy, done,
        input  ramEnable, ramWriteEnable, ramAddress, ramDataIn
    );

    modport slave (
        input  cpuValid, cpuWrite, cpuAddress, cpuWriteData,
        input  cmdValid, cmdOp, cmdSrc, cmdDst, cmdCount,
        input  ramDataOut,
        output cpuReady, cpuReadValid, cpuReadData,
        output cmdReady, busy, done,
        output ramEnable, ramWriteEnable, ramAddress, ramDataIn
    );
endinterface

// File: rtl/text_glyph_ram_controller.sv
// Glyph RAM port-B owner: arbitrates CPU byte accesses against the
// bulk fill/copy engine, one RAM access per cycle.
module text_glyph_ram_controller #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 8,
    parameter int GLYPH_BYTES = 16
) (
    input  logic                          clock,
    input  logic                          resetN,
    text_glyph_ram_controller_if.slave    bus
);
    localparam int RW = $clog2(GLYPH_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        COPY_RD,
        COPY_WR
    } state_t;

    state_t                state_q, state_d;
    logic                  rr_q, rr_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [DATA_WIDTH-1:0] fill_q, fill_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  cap_q, cap_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    logic                  cpu_req;
    logic                  eng_req;
    logic                  cpu_gnt;
    logic                  eng_gnt;
    logic                  accept;
    logic                  eng_wr;
    logic                  last_byte;
    logic [ADDR_WIDTH-1:0] eng_addr;
    logic [DATA_WIDTH-1:0] eng_data;
    logic [7:0]            cnt_m1;

    // rr_q set means the engine lost the last contest and wins the next
    assign cpu_req   = bus.cpuValid & resetN;
    assign eng_req   = (state_q != IDLE) & resetN;
    assign cpu_gnt   = cpu_req & (~eng_req | ~rr_q);
    assign eng_gnt   = eng_req & ~cpu_gnt;
    assign accept    = bus.cmdValid & (state_q == IDLE) & resetN;
    assign eng_wr    = (state_q != COPY_RD);
    assign last_byte = (idx_q == last_q);
    assign cnt_m1    = bus.cmdCount - 8'd1;
    assign eng_addr  = ((state_q == COPY_RD) ? src_q : dst_q) + idx_q;

    // the byte read one cycle ago is still on ramDataOut until captured
    assign eng_data  = (state_q == FILL) ? fill_q :
                       (cap_q ? bus.ramDataOut : hold_q);

    always_comb begin
        bus.cpuReady       = cpu_gnt;
        bus.cmdReady       = accept;
        bus.ramEnable      = cpu_gnt | eng_gnt;
        bus.ramWriteEnable = 1'b0;
        bus.ramAddress     = '0;
        bus.ramDataIn      = '0;
        unique case (1'b1)
            cpu_gnt: begin
                bus.ramWriteEnable = bus.cpuWrite;
                bus.ramAddress     = bus.cpuAddress;
                bus.ramDataIn      = bus.cpuWriteData;
            end
            eng_gnt: begin
                bus.ramWriteEnable = eng_wr;
                bus.ramAddress     = eng_addr;
                bus.ramDataIn      = eng_wr ? eng_data : '0;
            end
            default: ;
        endcase
        bus.cpuReadValid = rd_pend_q;
        bus.cpuReadData  = rd_pend_q ? bus.ramDataOut : '0;
        bus.busy         = busy_q;
        bus.done         = done_q;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        src_d     = src_q;
        dst_d     = dst_q;
        fill_d    = fill_q;
        cap_d     = 1'b0;
        done_d    = 1'b0;
        rd_pend_d = cpu_gnt & ~bus.cpuWrite;
        hold_d    = cap_q ? bus.ramDataOut : hold_q;
        rr_d      = (cpu_req & eng_req) ? cpu_gnt : rr_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    src_d   = ADDR_WIDTH'({bus.cmdSrc, {RW{1'b0}}});
                    dst_d   = ADDR_WIDTH'({bus.cmdDst, {RW{1'b0}}});
                    fill_d  = DATA_WIDTH'(bus.cmdSrc);
                    last_d  = ADDR_WIDTH'({cnt_m1, {RW{1'b1}}});
                    idx_d   = '0;
                    state_d = bus.cmdOp ? COPY_RD : FILL;
                end
            end
            FILL, COPY_WR: begin
                if (eng_gnt) begin
                    if (last_byte) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = (state_q == FILL) ? FILL : COPY_RD;
                    end
                end
            end
            COPY_RD: begin
                if (eng_gnt) begin
                    state_d = COPY_WR;
                    cap_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            idx_q     <= '0;
            last_q    <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            fill_q    <= '0;
            hold_q    <= '0;
            cap_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            fill_q    <= fill_d;
            hold_q    <= hold_d;
            cap_q     <= cap_d;
            rd_pend_q <= rd_pend_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end
endmodule

// File: doc/text_glyph_ram_controller.md
Name: text_glyph_ram_controller

Overview:
Owns the read/write port (port B) of the 4096-byte text glyph RAM and shares it between two requesters.
- A CPU single-byte read/write channel.
- A bulk engine that fills glyph ranges with a constant byte or copies glyphs (16 bytes each) from one code point range to another.
The controller arbitrates the single RAM port cycle by cycle and hides RAM read latency from the bulk engine. Port A (renderer) is untouched.

Parameters:
ADDR_WIDTH, 12, RAM byte address width (256 glyphs x 16 rows)
DATA_WIDTH, 8, RAM data width
GLYPH_BYTES, 16, bytes per glyph; address = {glyphIndex, row[3:0]}

Ports:
clock  in  1  system clock, rising edge
resetN  in  1  asynchronous active-low reset
cpuValid  in  1  CPU access request
cpuReady  out  1  CPU request granted this cycle (combinational)
cpuWrite  in  1  1=write, 0=read
cpuAddress  in  ADDR_WIDTH  CPU byte address
cpuWriteData  in  DATA_WIDTH  CPU write byte
cpuReadValid  out  1  read data valid (one-cycle pulse)
cpuReadData  out  DATA_WIDTH  read byte, valid only while cpuReadValid=1
cmdValid  in  1  bulk command request
cmdReady  out  1  command accepted (high only in IDLE)
cmdOp  in  1  0=FILL, 1=COPY
cmdSrc  in  8  FILL: fill byte; COPY: first source glyph index
cmdDst  in  8  first destination glyph index
cmdCount  in  8  glyph count; 0 means 256
busy  out  1  bulk engine active
done  out  1  one-cycle pulse on command completion
ramEnable  out  1  to RAM enableB
ramWriteEnable  out  1  to RAM writeEnableB
ramAddress  out  ADDR_WIDTH  to RAM addressB
ramDataIn  out  DATA_WIDTH  to RAM dataInB
ramDataOut  in  DATA_WIDTH  from RAM dataOutB (registered, 1-cycle latency)

Behaviour:
- Reset (resetN low, async): state IDLE; every output 0; arbitration pointer favours CPU; internal counters 0.
- RAM-side outputs are combinational from the current grant. ramEnable=0 when no grant.
- Slot arbitration, one RAM access per cycle:
  - Only CPU requesting: CPU wins.
  - Only engine requesting: engine wins.
  - Both requesting: round-robin. The loser of the last contested slot wins the next contested slot. The first contest after reset goes to CPU.
- CPU grant at cycle T:
  - cpuReady=1, ramEnable=1, ramWriteEnable=cpuWrite, ramAddress=cpuAddress, ramDataIn=cpuWriteData.
  - For a read: cpuReadValid=1 at T+1, cpuReadData=ramDataOut (pass-through).
  - CPU must hold its request until cpuReady.
- Command acceptance: cmdValid && state==IDLE. That cycle cmdReady=1; operands latched; next cycle busy=1 and state = FILL or COPY_RD.
- FILL:
  - Writes cmdSrc to bytes dst*16 through (dst+count)*16-1, ascending, one byte per granted slot.
  - Glyph index wraps modulo 256.
- COPY, per byte i:
  - COPY_RD: granted slot reads src byte i.
  - The cycle after that grant: ramDataOut is captured into an internal holding register, unconditionally, even if the CPU owns that cycle.
  - COPY_WR: granted slot writes the held byte to dst byte i.
  - Source and destination indices both wrap modulo 256.
  - Processing is strictly ascending. An overlapping range with src<dst<src+count propagates copied data; this is defined behaviour, not an error.
- Completion:
  - After the final write is granted, the next cycle has done=1, busy=0, state=IDLE.
  - cmdReady may be 1 in that same cycle.
- Uncontested timing: FILL takes 16·N write cycles; COPY takes 32·N cycles (N = count, 0→256).
- CPU accesses during a bulk operation are legal. A CPU write to a byte the engine later touches is overwritten.
- Reset mid-operation aborts immediately. RAM keeps partially written contents. No done pulse.

Test Plan:
- Reset → all outputs 0. CPU write 0xA5 to 0x123, then read 0x123 → cpuReady same cycle as cpuValid; cpuReadValid next cycle with 0xA5.
- FILL cmdSrc=0xFF, cmdDst=0x00, cmdCount=0, no CPU traffic → 4096 consecutive write cycles, addresses 0x000..0xFFF; done 4097 cycles after acceptance; spot reads return 0xFF.
- Preload glyph 0x41 rows with 0x00..0x0F, COPY src=0x41 dst=0x80 count=1 → 32 cycles; bytes 0x800..0x80F = 0x00..0x0F; done pulse exactly once.
- FILL dst=0xFF count=2 value 0x3C → bytes 0xFF0..0xFFF and 0x000..0x00F written; 0x010 untouched.
- COPY running with cpuValid held continuously → grants strictly alternate CPU/engine; copy finishes in 64 cycles; copied data correct despite CPU reads between engine read and write.
- resetN asserted mid-FILL (after 100 writes) → outputs 0 immediately; no done; new command accepted after release.
